// File: rtl/axi_scratchpad_slave.sv
// AXI4 scratchpad slave: DEPTH x 32-bit words, independent read/write FSMs.
// Define AXI_SCRATCHPAD_WRAP_EN to accept WRAP bursts (len 1/3/7/15).
module axi_scratchpad_slave #(
    parameter int DEPTH    = 1024,
    parameter int ID_WIDTH = 2
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic [2:0]          s_axi_awprot,
    input  logic [3:0]          s_axi_awqos,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic [2:0]          s_axi_arprot,
    input  logic [3:0]          s_axi_arqos,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

`ifdef AXI_SCRATCHPAD_WRAP_EN
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [1:0]  burst,
                                              input logic [7:0]  len);
        logic [31:0] inc;
        logic [31:0] mask;
        inc  = a + 32'd4;
        // legal wrap lengths make (len+1)*4-1 == {len, 2'b11}
        mask = {22'd0, len, 2'b11};
        next_addr = a;
        if (burst == BURST_INCR)
            next_addr = inc;
        else if (burst == BURST_WRAP)
            next_addr = (a & ~mask) | (inc & mask);
    endfunction

    function automatic logic req_err(input logic [31:0] a,
                                     input logic [7:0]  len,
                                     input logic [2:0]  size,
                                     input logic [1:0]  burst);
        req_err = (size != 3'b010);
        unique case (burst)
            BURST_FIXED, BURST_INCR: begin end
            BURST_WRAP: begin
                if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 ||
                      len == 8'd15) || a[1:0] != 2'b00)
                    req_err = 1'b1;
            end
            default: req_err = 1'b1;
        endcase
    endfunction
`else
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [1:0]  burst,
                                              input logic [7:0]  len);
        logic unused_len;
        unused_len = ^len;
        next_addr  = (burst == BURST_INCR) ? a + 32'd4 : a;
    endfunction

    function automatic logic req_err(input logic [31:0] a,
                                     input logic [7:0]  len,
                                     input logic [2:0]  size,
                                     input logic [1:0]  burst);
        logic unused_args;
        unused_args = ^{a, len};
        req_err = (size != 3'b010) ||
                  !(burst == BURST_FIXED || burst == BURST_INCR);
    endfunction
`endif

    logic [31:0] mem [DEPTH];

    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                               s_axi_awqos, s_axi_arlock, s_axi_arcache,
                               s_axi_arprot, s_axi_arqos};

    wstate_e               w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [31:0]           waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [7:0]            wbeat_q, wbeat_d;
    logic                  werr_q, werr_d;
    logic                  w_ready;
    logic                  mem_we;
    logic                  w_last_beat;
    logic                  w_err_now;

    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        wid_d       = wid_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wburst_d    = wburst_q;
        wbeat_d     = wbeat_q;
        werr_d      = werr_q;
        w_ready     = 1'b0;
        mem_we      = 1'b0;
        w_last_beat = (wbeat_q == wlen_q);
        // an error seen on any beat blocks that beat and all later ones
        w_err_now   = werr_q | (s_axi_wlast != w_last_beat);
        unique case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (s_axi_awvalid && awready_q) begin
                    awready_d = 1'b0;
                    w_state_d = W_DATA;
                    wid_d     = s_axi_awid;
                    waddr_d   = s_axi_awaddr;
                    wlen_d    = s_axi_awlen;
                    wburst_d  = s_axi_awburst;
                    wbeat_d   = 8'd0;
                    werr_d    = req_err(s_axi_awaddr, s_axi_awlen,
                                        s_axi_awsize, s_axi_awburst);
                end
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (s_axi_wvalid) begin
                    mem_we  = !w_err_now;
                    waddr_d = next_addr(waddr_q, wburst_q, wlen_q);
                    wbeat_d = wbeat_q + 8'd1;
                    werr_d  = w_err_now;
                    if (s_axi_wlast || w_last_beat) begin
                        w_state_d = W_RESP;
                        bvalid_d  = 1'b1;
                        bid_d     = wid_q;
                        bresp_d   = w_err_now ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
        end
    end

    // storage is never reset so contents survive a mid-burst reset
    always_ff @(posedge clock_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b])
                    mem[waddr_q[2 +: AW]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    rstate_e               r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [31:0]           raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [1:0]            rburst_q, rburst_d;
    logic [7:0]            rbeat_q, rbeat_d;
    logic                  rerr_q, rerr_d;
    logic                  ar_err;
    logic [31:0]           r_next;

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rbeat_d   = rbeat_q;
        rerr_d    = rerr_q;
        ar_err    = req_err(s_axi_araddr, s_axi_arlen,
                            s_axi_arsize, s_axi_arburst);
        r_next    = next_addr(raddr_q, rburst_q, rlen_q);
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                    rid_d     = s_axi_arid;
                    raddr_d   = s_axi_araddr;
                    rlen_d    = s_axi_arlen;
                    rburst_d  = s_axi_arburst;
                    rbeat_d   = 8'd0;
                    rerr_d    = ar_err;
                    rvalid_d  = 1'b1;
                    rlast_d   = (s_axi_arlen == 8'd0);
                    rresp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = ar_err ? '0 : mem[s_axi_araddr[2 +: AW]];
                end
            end
            R_DATA: begin
                if (s_axi_rready && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = r_next;
                        rbeat_d = rbeat_q + 8'd1;
                        rlast_d = ((rbeat_q + 8'd1) == rlen_q);
                        rdata_d = rerr_q ? '0 : mem[r_next[2 +: AW]];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
            rerr_q    <= rerr_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = w_ready;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;

endmodule

// File: tb/tb_axi_scratchpad_slave.sv
// Directed testbench for axi_scratchpad_slave.
// Expectations follow AXI_SCRATCHPAD_WRAP_EN when it is defined.
module tb_axi_scratchpad_slave;
    localparam int ID_W  = 2;
    localparam int DEPTH = 1024;
    localparam int TMO   = 50;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ID_W-1:0] awid, arid, bid, rid;
    logic [31:0]     awaddr, araddr, wdata, rdata;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, wvalid, wready, wlast;
    logic [3:0]      wstrb;
    logic            bvalid, bready, arvalid, arready;
    logic            rvalid, rready, rlast;

    int errors = 0;
    int checks = 0;

    logic [31:0]     wd [16];
    logic [3:0]      ws [16];
    logic [31:0]     rd [16];
    logic [1:0]      rr [16];
    logic            rl [16];
    logic [ID_W-1:0] rid_s;

    always #5 clk = ~clk;

    axi_scratchpad_slave #(.DEPTH(DEPTH), .ID_WIDTH(ID_W)) dut (
        .clock_i(clk), .reset_i(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awlock(1'b0), .s_axi_awcache(4'h3), .s_axi_awprot(3'h0),
        .s_axi_awqos(4'h0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arlock(1'b0), .s_axi_arcache(4'h3), .s_axi_arprot(3'h0),
        .s_axi_arqos(4'h0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic timeout(input string what);
        checks++;
        errors++;
        $display("FAIL timeout_%s: handshake never came within %0d cycles", what, TMO);
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int nbeats,
                            output logic [1:0] resp, output logic [ID_W-1:0] rbid);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timeout("aw");
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) timeout("w");
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (bvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timeout("b");
        resp = bresp; rbid = bid;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timeout("ar");
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (rvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) timeout("r");
            rd[b] = rdata; rr[b] = rresp; rl[b] = rlast; rid_s = rid;
            @(posedge clk); #1;
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b want 00000",
                     {awready, wready, bvalid, arready, rvalid});
        end
        checks++;
        if ({bid, bresp, rid, rresp, rlast} !== 9'b0) begin
            errors++;
            $display("FAIL reset_fields: got %b want 0", {bid, bresp, rid, rresp, rlast});
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        rst = 1'b0;
        checks++;
        if ({awready, arready} !== 2'b00) begin
            errors++; $display("FAIL ready_early: got %b want 00", {awready, arready});
        end
        @(posedge clk); #1;
        checks++;
        if ({awready, arready} !== 2'b11) begin
            errors++; $display("FAIL ready_after_reset: got %b want 11", {awready, arready});
        end
    endtask

    task automatic test_incr();
        logic [1:0] resp;
        logic [ID_W-1:0] b;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        do_write(2'd1, 32'h10, 8'd3, 3'b010, 2'b01, 4, resp, b);
        checks++;
        if ({resp, b} !== {2'b00, 2'd1}) begin
            errors++; $display("FAIL incr_bresp: got resp %b id %0d want 00 id 1", resp, b);
        end
        do_read(2'd3, 32'h10, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rd[i], rr[i], rl[i]} !== {32'hA0 + i, 2'b00, i == 3}) begin
                errors++;
                $display("FAIL incr_beat%0d: got %h/%b/%b want %h/00/%b",
                         i, rd[i], rr[i], rl[i], 32'hA0 + i, i == 3);
            end
        end
        checks++;
        if (rid_s !== 2'd3) begin
            errors++; $display("FAIL incr_rid: got %0d want 3", rid_s);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        logic [ID_W-1:0] b;
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(2'd0, 32'h100, 8'd0, 3'b010, 2'b01, 1, resp, b);
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'h2;
        do_write(2'd0, 32'h100, 8'd0, 3'b010, 2'b01, 1, resp, b);
        checks++;
        if (resp !== 2'b00) begin
            errors++; $display("FAIL strobe_bresp: got %b want 00", resp);
        end
        do_read(2'd0, 32'h100, 8'd0, 3'b010, 2'b01);
        checks++;
        if (rd[0] !== 32'h1122FF44) begin
            errors++; $display("FAIL strobe_data: got %h want 1122ff44", rd[0]);
        end
    endtask

    task automatic test_write_errors();
        logic [1:0] resp;
        logic [ID_W-1:0] b;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h55550000 + i; ws[i] = 4'hF; end
        do_write(2'd0, 32'h200, 8'd3, 3'b010, 2'b01, 4, resp, b);
        wd[0] = 32'hDEAD0000; ws[0] = 4'h0;
        wd[1] = 32'hDEAD0001; ws[1] = 4'hF;
        do_write(2'd2, 32'h200, 8'd3, 3'b010, 2'b01, 2, resp, b);
        checks++;
        if ({resp, b} !== {2'b10, 2'd2}) begin
            errors++; $display("FAIL early_wlast_bresp: got %b id %0d want 10 id 2", resp, b);
        end
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(2'd0, 32'h20C, 8'd0, 3'b001, 2'b01, 1, resp, b);
        checks++;
        if (resp !== 2'b10) begin
            errors++; $display("FAIL size_bresp: got %b want 10", resp);
        end
        do_read(2'd0, 32'h200, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== 32'h55550000 + i) begin
                errors++;
                $display("FAIL err_unchanged%0d: got %h want %h", i, rd[i], 32'h55550000 + i);
            end
        end
    endtask

    task automatic test_read_backpressure();
        int n;
        arid = 2'b10; araddr = 32'h10; arlen = 8'd1; arsize = 3'b010;
        arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timeout("ar_bp");
        @(posedge clk); #1;
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin
            errors++; $display("FAIL rvalid_latency: got %b want 1", rvalid);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({rvalid, rlast, rid, rdata, rresp} !== {1'b1, 1'b0, 2'b10, 32'hA0, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v%b l%b id%0d %h want v1 l0 id2 000000a0",
                         c, rvalid, rlast, rid, rdata);
            end
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rvalid, rlast, rid, rdata, rresp} !== {1'b1, 1'b1, 2'b10, 32'hA1, 2'b00}) begin
            errors++;
            $display("FAIL bp_beat1: got v%b l%b id%0d %h want v1 l1 id2 000000a1",
                     rvalid, rlast, rid, rdata);
        end
        @(posedge clk); #1;
        rready = 1'b0;
        checks++;
        if ({rvalid, arready} !== 2'b01) begin
            errors++; $display("FAIL bp_done: got %b want 01", {rvalid, arready});
        end
    endtask

    task automatic test_wrap();
        logic [1:0] resp;
        logic [ID_W-1:0] b;
        logic [31:0] exp [4];
        logic [1:0] exp_resp;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + i; ws[i] = 4'hF; end
        do_write(2'd0, 32'h0, 8'd3, 3'b010, 2'b01, 4, resp, b);
`ifdef AXI_SCRATCHPAD_WRAP_EN
        exp[0] = 32'hB3; exp[1] = 32'hB0; exp[2] = 32'hB1; exp[3] = 32'hB2;
        exp_resp = 2'b00;
`else
        for (int i = 0; i < 4; i++) exp[i] = 32'h0;
        exp_resp = 2'b10;
`endif
        do_read(2'd1, 32'h0C, 8'd3, 3'b010, 2'b10);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rd[i], rr[i], rl[i]} !== {exp[i], exp_resp, i == 3}) begin
                errors++;
                $display("FAIL wrap_beat%0d: got %h/%b/%b want %h/%b/%b",
                         i, rd[i], rr[i], rl[i], exp[i], exp_resp, i == 3);
            end
        end
    endtask

    task automatic test_fixed_alias();
        logic [1:0] resp;
        logic [ID_W-1:0] b;
        wd[0] = 32'h1111; wd[1] = 32'h2222; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(2'd0, 32'h300, 8'd1, 3'b010, 2'b00, 2, resp, b);
        wd[0] = 32'h9999;
        do_write(2'd0, 32'h300, 8'd0, 3'b010, 2'b11, 1, resp, b);
        checks++;
        if (resp !== 2'b10) begin
            errors++; $display("FAIL burst11_bresp: got %b want 10", resp);
        end
        do_read(2'd0, 32'h300 + DEPTH * 4, 8'd0, 3'b010, 2'b01);
        checks++;
        if ({rd[0], rr[0]} !== {32'h2222, 2'b00}) begin
            errors++; $display("FAIL fixed_alias: got %h/%b want 00002222/00", rd[0], rr[0]);
        end
        do_read(2'd0, 32'h300, 8'd0, 3'b010, 2'b11);
        checks++;
        if ({rd[0], rr[0], rl[0]} !== {32'h0, 2'b10, 1'b1}) begin
            errors++; $display("FAIL burst11_read: got %h/%b/%b want 0/10/1", rd[0], rr[0], rl[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp;
        logic [ID_W-1:0] b;
        int n;
        wd[0] = 32'hDEAD0001; ws[0] = 4'hF;
        do_write(2'd0, 32'h500, 8'd0, 3'b010, 2'b01, 1, resp, b);
        awid = 2'd1; awaddr = 32'h500; awlen = 8'd0; awsize = 3'b010;
        awburst = 2'b01; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timeout("aw_b2b");
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata = 32'hBEEF0002; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        arid = 2'd1; araddr = 32'h500; arlen = 8'd0; arsize = 3'b010;
        arburst = 2'b01; arvalid = 1'b1;
        checks++;
        if ({wready, arready} !== 2'b11) begin
            errors++; $display("FAIL b2b_ready: got %b want 11", {wready, arready});
        end
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        checks++;
        if ({rvalid, rdata} !== {1'b1, 32'hDEAD0001}) begin
            errors++; $display("FAIL read_first: got v%b %h want v1 dead0001", rvalid, rdata);
        end
        checks++;
        if ({bvalid, bresp, bid} !== {1'b1, 2'b00, 2'd1}) begin
            errors++; $display("FAIL b2b_b: got %b want 1_00_01", {bvalid, bresp, bid});
        end
        rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        do_read(2'd0, 32'h500, 8'd0, 3'b010, 2'b01);
        checks++;
        if (rd[0] !== 32'hBEEF0002) begin
            errors++; $display("FAIL b2b_new: got %h want beef0002", rd[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen_b;
        awid = 2'd1; awaddr = 32'h400; awlen = 8'd7; awsize = 3'b010;
        awburst = 2'b01; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timeout("aw_mid");
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wdata = 32'hC0 + b; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) timeout("w_mid");
            @(posedge clk); #1;
        end
        wdata = 32'hC2;
        rst = 1'b1;
        #1;
        wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({awready, bvalid} !== 2'b00) begin
            errors++; $display("FAIL mid_release: got %b want 00", {awready, bvalid});
        end
        @(posedge clk); #1;
        checks++;
        if (awready !== 1'b1) begin
            errors++; $display("FAIL mid_awready: got %b want 1", awready);
        end
        bready = 1'b1;
        seen_b = 1'b0;
        repeat (4) begin
            if (bvalid === 1'b1) seen_b = 1'b1;
            @(posedge clk); #1;
        end
        bready = 1'b0;
        checks++;
        if (seen_b !== 1'b0) begin
            errors++; $display("FAIL mid_no_b: got bvalid seen=%b want 0", seen_b);
        end
        do_read(2'd0, 32'h400, 8'd1, 3'b010, 2'b01);
        checks++;
        if ({rd[0], rd[1]} !== {32'hC0, 32'hC1}) begin
            errors++; $display("FAIL mid_kept: got %h %h want c0 c1", rd[0], rd[1]);
        end
        do_read(2'd0, 32'h10, 8'd0, 3'b010, 2'b01);
        checks++;
        if (rd[0] !== 32'hA0) begin
            errors++; $display("FAIL mid_old: got %h want a0", rd[0]);
        end
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_incr();
        test_strobe();
        test_write_errors();
        test_read_backpressure();
        test_wrap();
        test_fixed_alias();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_scratchpad_slave.md
AXI_SCRATCHPAD_SLAVE -- requirements
Module: axi_scratchpad_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, giving the memory size in 32-bit words (power of two, at least 16).
REQ-002 SHALL have parameter ID_WIDTH, default 2, giving the AXI ID width.
REQ-003 SHALL have port clock_i, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_i, input, width 1: reset, asynchronous, active-high.
REQ-005 SHALL have AW-channel inputs s_axi_awid (ID_WIDTH), s_axi_awaddr (32), s_axi_awlen (8), s_axi_awsize (3), s_axi_awburst (2) and s_axi_awvalid (1); output s_axi_awready (1).
REQ-006 SHALL have W-channel inputs s_axi_wdata (32), s_axi_wstrb (4), s_axi_wlast (1) and s_axi_wvalid (1); output s_axi_wready (1).
REQ-007 SHALL have B-channel outputs s_axi_bid (ID_WIDTH), s_axi_bresp (2) and s_axi_bvalid (1); input s_axi_bready (1).
REQ-008 SHALL have AR-channel inputs s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst and s_axi_arvalid, with widths as on AW; output s_axi_arready (1).
REQ-009 SHALL have R-channel outputs s_axi_rid (ID_WIDTH), s_axi_rdata (32), s_axi_rresp (2), s_axi_rlast (1) and s_axi_rvalid (1); input s_axi_rready (1).
REQ-010 SHALL accept lock/cache/prot/qos inputs on AW and AR and ignore them.

Function
REQ-011 SHALL store DEPTH words; word index = addr[2 +: log2(DEPTH)]; higher address bits are ignored, so addresses alias.
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
REQ-013 W_IDLE: awready=1; on the AW handshake, capture id/addr/len/size/burst, clear the beat counter, go to W_DATA.
REQ-014 W_DATA: wready=1; each W handshake writes the bytes enabled by wstrb, advances the address per burst type and increments the beat counter.
REQ-015 W_DATA SHALL go to W_RESP on the beat where wlast=1 or where beat counter == len, whichever comes first.
REQ-016 W_RESP: bvalid=1, bid=captured id; bvalid and bid SHALL be held until bready; then go to W_IDLE.
REQ-017 bresp SHALL be SLVERR (2'b10) if awsize != 3'b010, if the burst type is unsupported, or if the wlast position disagrees with len; otherwise OKAY.
REQ-018 On an SLVERR write, all beats SHALL still be accepted and no memory bytes SHALL be modified.
REQ-019 Read FSM SHALL have states R_IDLE and R_DATA.
REQ-020 R_IDLE: arready=1; on the AR handshake, capture fields and go to R_DATA.
REQ-021 First rvalid SHALL occur exactly 1 cycle after the AR handshake (registered memory read).
REQ-022 Each R handshake SHALL present the next beat on the following cycle, giving 1 beat per cycle under continuous rready.
REQ-023 rdata/rid/rresp/rlast SHALL be held stable while rvalid=1 and rready=0.
REQ-024 rlast=1 on beat len; after its handshake, return to R_IDLE.
REQ-025 Read error conditions SHALL be as in REQ-017 without the wlast check; on error, rdata=0 and rresp=SLVERR on every beat, with the full len+1 beats returned.
REQ-026 Burst FIXED (00): address constant; INCR (01): address += 4 per beat; 2'b11: unsupported.
REQ-027 Read and write channels SHALL be independent; a same-cycle read and write to the same word returns the old data (read-first).
REQ-028 At most one outstanding transaction per direction; awready/arready = 0 outside their IDLE state.

Reset
REQ-029 While reset_i=1: all ready/valid outputs 0; bid, bresp, rid, rdata, rresp and rlast 0; FSMs in W_IDLE/R_IDLE.
REQ-030 awready and arready SHALL be registered and rise on the first clock after reset_i deasserts.
REQ-031 Reset asserted mid-burst SHALL abandon the transaction with no B/R response, and memory contents SHALL be preserved.

Configuration
REQ-032 Macro AXI_SCRATCHPAD_WRAP_EN defined: WRAP bursts (2'b10) are supported for len in {1,3,7,15}.
REQ-033 Under WRAP, the address increments by 4 and wraps within the (len+1)*4-byte aligned window; a WRAP with any other len, or an unaligned start address, is an error.
REQ-034 Macro undefined: WRAP is unsupported and handled per REQ-017/REQ-018/REQ-025.

Verification
REQ-035 INCR write awaddr=0x10, len=3, data 0xA0..0xA3, wstrb=0xF -> bresp=OKAY; an INCR read of the same range returns 0xA0..0xA3, rlast on beat 3, rresp=OKAY.
REQ-036 Write 0x11223344 then a single-beat write 0xFFFFFFFF with wstrb=0x2 to the same word -> readback is 0x1122FF44.
REQ-037 awlen=3 with wlast asserted on beat 1 -> bresp=SLVERR after 2 beats, and the targeted memory is unchanged.
REQ-038 Read len=1 with rready low for 3 cycles on beat 0 -> beat 0 is held stable, then 2 beats complete, and rid equals arid=2'b10.
REQ-039 WRAP read araddr=0x0C, len=3 -> with macro: words at 0x0C,0x00,0x04,0x08, OKAY; without macro: 4 beats of rdata=0 with SLVERR.
REQ-040 reset_i pulsed during beat 2 of a len=7 write -> no bvalid; awready=1 the cycle after release; earlier-written words are still readable.
